ifft: RTL and testbench

Radix-2, decimation-in-time, in-place inverse FFT core with N = 2^TOTAL_STAGE complex points.
- Loads one frame of frequency-domain samples addressed by index, computes the 1/N-scaled inverse transform with a single time-shared butterfly, then streams time-domain samples out in natural order with an address tag.
- Sits after a frequency-domain processing block, standalone in the FFT/IFFT datapath.

---
 rtl/ifft_if.sv | 30 +++
 rtl/ifft.sv | 161 ++++++++++++++++
 tb/tb_ifft.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifft_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ifft_if : sample-in / sample-out bus of the ifft core                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface ifft_if #(
  parameter int TOTAL_STAGE = 4,
  parameter int REAL_WIDTH  = 16,
  parameter int IMGN_WIDTH  = 16
);
  logic        [TOTAL_STAGE-1:0] iaddr;
  logic signed [REAL_WIDTH-1:0]  iReal;
  logic signed [IMGN_WIDTH-1:0]  iImag;
  logic                          ien;
  logic signed [REAL_WIDTH-1:0]  oReal;
  logic signed [IMGN_WIDTH-1:0]  oImag;
  logic        [TOTAL_STAGE-1:0] oaddr;
  logic                          oen;

  modport master (
    output iaddr, iReal, iImag, ien,
    input  oReal, oImag, oaddr, oen
  );

  modport slave (
    input  iaddr, iReal, iImag, ien,
    output oReal, oImag, oaddr, oen
  );
endinterface
`default_nettype wire

// File: rtl/ifft.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ifft : radix-2 DIT in-place inverse FFT, one time-shared butterfly, 1/N    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ifft #(
  parameter int TOTAL_STAGE = 4,
  parameter int REAL_WIDTH  = 16,
  parameter int IMGN_WIDTH  = 16
) (
  input wire     iclk,
  input wire     rst_n,
  ifft_if.slave  bus
);
  localparam int  N      = 1 << TOTAL_STAGE;
  localparam int  HALF   = N / 2;
  localparam int  STW    = $clog2(TOTAL_STAGE);
  localparam int  MW     = (REAL_WIDTH > IMGN_WIDTH) ? REAL_WIDTH : IMGN_WIDTH;
  localparam int  PW     = MW + 18;
  localparam int  FRAC   = 14;
  localparam real TWO_PI = 6.283185307179586;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t                      state;
  logic [STW-1:0]              stage;
  logic [TOTAL_STAGE-1:0]      bfly;

  logic signed [REAL_WIDTH-1:0] mem_re [N];
  logic signed [IMGN_WIDTH-1:0] mem_im [N];
  logic signed [15:0]           tw_re  [HALF];
  logic signed [15:0]           tw_im  [HALF];

  logic [TOTAL_STAGE-1:0] h, j, top, bot, wr_addr, out_idx;
  logic [TOTAL_STAGE-2:0] tw_idx;

  logic signed [REAL_WIDTH-1:0] a_re, b_re, new_top_re, new_bot_re;
  logic signed [IMGN_WIDTH-1:0] a_im, b_im, new_top_im, new_bot_im;
  logic signed [15:0]           w_re, w_im;
  logic signed [PW-1:0]         prod_rr, prod_ii, prod_ri, prod_ir, t_re, t_im;

  function automatic logic [TOTAL_STAGE-1:0] bitrev(input logic [TOTAL_STAGE-1:0] a);
    logic [TOTAL_STAGE-1:0] r;
    for (int i = 0; i < TOTAL_STAGE; i++) r[i] = a[TOTAL_STAGE-1-i];
    return r;
  endfunction

  // Q2.14 rounded to nearest; evaluated only on constant arguments
  function automatic logic signed [15:0] q14(input real x);
    real v;
    v = x * 16384.0;
    if (v >= 0.0) return 16'($rtoi(v + 0.5));
    return 16'(-$rtoi(0.5 - v));
  endfunction

  function automatic logic signed [PW-1:0] clip(input logic signed [PW-1:0] v, input int w);
    logic signed [PW-1:0] hi, lo;
    hi = (PW'(1) <<< (w - 1)) - PW'(1);
    lo = -hi - PW'(1);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  for (genvar k = 0; k < HALF; k++) begin : g_rom
    assign tw_re[k] = q14($cos(TWO_PI * k / N));
    assign tw_im[k] = q14($sin(TWO_PI * k / N));
  end

  // Butterfly addressing: h = 2^stage, top = (b/h)*2h + b%h, twiddle k = j*N/(2h)
  always_comb begin
    h       = TOTAL_STAGE'(1) << stage;
    j       = bfly & (h - 1'b1);
    top     = (((bfly >> stage) << stage) << 1) | j;
    bot     = top | h;
    tw_idx  = (TOTAL_STAGE-1)'(j << (STW'(TOTAL_STAGE - 1) - stage));
    wr_addr = bitrev(bus.iaddr);
    out_idx = bus.oen ? bus.oaddr + 1'b1 : '0;
  end

  always_comb begin
    a_re    = mem_re[top];
    a_im    = mem_im[top];
    b_re    = mem_re[bot];
    b_im    = mem_im[bot];
    w_re    = tw_re[tw_idx];
    w_im    = tw_im[tw_idx];
    prod_rr = PW'(b_re) * PW'(w_re);
    prod_ii = PW'(b_im) * PW'(w_im);
    prod_ri = PW'(b_re) * PW'(w_im);
    prod_ir = PW'(b_im) * PW'(w_re);
    t_re    = (prod_rr - prod_ii) >>> FRAC;
    t_im    = (prod_ri + prod_ir) >>> FRAC;
    // Halving every stage gives the overall 1/N scale
    new_top_re = REAL_WIDTH'(clip((PW'(a_re) + t_re) >>> 1, REAL_WIDTH));
    new_bot_re = REAL_WIDTH'(clip((PW'(a_re) - t_re) >>> 1, REAL_WIDTH));
    new_top_im = IMGN_WIDTH'(clip((PW'(a_im) + t_im) >>> 1, IMGN_WIDTH));
    new_bot_im = IMGN_WIDTH'(clip((PW'(a_im) - t_im) >>> 1, IMGN_WIDTH));
  end

  // Sample memory carries no reset; its contents are irrelevant until loaded
  always_ff @(posedge iclk) begin
    if (state == LOAD && bus.ien) begin
      mem_re[wr_addr] <= bus.iReal;
      mem_im[wr_addr] <= bus.iImag;
    end else if (state == CALC) begin
      mem_re[top] <= new_top_re;
      mem_im[top] <= new_top_im;
      mem_re[bot] <= new_bot_re;
      mem_im[bot] <= new_bot_im;
    end
  end

  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      stage     <= '0;
      bfly      <= '0;
      bus.oReal <= '0;
      bus.oImag <= '0;
      bus.oaddr <= '0;
      bus.oen   <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (bus.ien && (&bus.iaddr)) begin
            state <= CALC;
            stage <= '0;
            bfly  <= '0;
          end
        end
        CALC: begin
          if (bfly == TOTAL_STAGE'(HALF - 1)) begin
            bfly <= '0;
            if (stage == STW'(TOTAL_STAGE - 1)) state <= OUT;
            else                                stage <= stage + 1'b1;
          end else begin
            bfly <= bfly + 1'b1;
          end
        end
        OUT: begin
          if (bus.oen && (&bus.oaddr)) begin
            bus.oen <= 1'b0;
            state   <= LOAD;
          end else begin
            bus.oReal <= mem_re[out_idx];
            bus.oImag <= mem_im[out_idx];
            bus.oaddr <= out_idx;
            bus.oen   <= 1'b1;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_ifft.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ifft : randomized self-checking bench for ifft against an IDFT model    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ifft;
  localparam int TS   = 4;
  localparam int RW   = 16;
  localparam int IW   = 16;
  localparam int N    = 1 << TS;
  localparam int HALF = N / 2;
  localparam int LAT  = TS * N / 2 + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ifft_if #(.TOTAL_STAGE(TS), .REAL_WIDTH(RW), .IMGN_WIDTH(IW)) bus ();

  ifft #(.TOTAL_STAGE(TS), .REAL_WIDTH(RW), .IMGN_WIDTH(IW)) dut (
    .iclk  (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  int sr [N], si [N];          // staged frame data by bin
  int xr [N], xi [N];          // what the DUT should hold, last write wins
  int er [N], ei [N];          // expected time-domain outputs
  int gr [N], gi [N];          // captured outputs of the last frame
  int twr [HALF], twi [HALF];

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int q14(input real x);
    real v;
    v = x * 16384.0;
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(0.5 - v);
  endfunction

  function automatic int sat16(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic int bitrev(input int a);
    int r = 0;
    for (int i = 0; i < TS; i++) if (a & (1 << i)) r |= 1 << (TS - 1 - i);
    return r;
  endfunction

  // In-place DIT inverse FFT with 1/2 per stage, using plain integer arithmetic
  task automatic compute_model();
    int re [N], im [N];
    int h, jj, top, bot, k;
    longint tr, ti, ar, ai;
    for (int i = 0; i < N; i++) begin
      re[bitrev(i)] = xr[i];
      im[bitrev(i)] = xi[i];
    end
    for (int s = 0; s < TS; s++) begin
      for (int b = 0; b < HALF; b++) begin
        h   = 1 << s;
        jj  = b % h;
        top = (b / h) * 2 * h + jj;
        bot = top + h;
        k   = jj * N / (2 * h);
        tr  = (longint'(re[bot]) * twr[k] - longint'(im[bot]) * twi[k]) >>> 14;
        ti  = (longint'(re[bot]) * twi[k] + longint'(im[bot]) * twr[k]) >>> 14;
        ar  = re[top];
        ai  = im[top];
        re[top] = sat16((ar + tr) >>> 1);
        im[top] = sat16((ai + ti) >>> 1);
        re[bot] = sat16((ar - tr) >>> 1);
        im[bot] = sat16((ai - ti) >>> 1);
      end
    end
    for (int i = 0; i < N; i++) begin
      er[i] = re[i];
      ei[i] = im[i];
    end
  endtask

  task automatic write_sample(input int a, input int r, input int i);
    bus.ien   = 1'b1;
    bus.iaddr = TS'(a);
    bus.iReal = RW'(r);
    bus.iImag = IW'(i);
    xr[a] = r;
    xi[a] = i;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_noise();
    bus.ien   = 1'b1;
    bus.iaddr = TS'($urandom_range(0, N - 1));
    bus.iReal = RW'($urandom);
    bus.iImag = IW'($urandom);
  endtask

  // Loads 0..14 in shuffled (or descending) order with optional junk overwrites, then 15
  task automatic load_frame(input int mode, input int junk);
    int ord [N-1];
    int t, p;
    for (int i = 0; i < N - 1; i++) ord[i] = (mode == 1) ? (N - 2 - i) : i;
    if (mode == 2) begin
      for (int i = N - 2; i > 0; i--) begin
        p = $urandom_range(0, i);
        t = ord[i]; ord[i] = ord[p]; ord[p] = t;
      end
    end
    for (int i = 0; i < junk; i++)
      write_sample($urandom_range(0, N - 2), int'($urandom_range(0, 65535)) - 32768, 77);
    for (int i = 0; i < N - 1; i++) write_sample(ord[i], sr[ord[i]], si[ord[i]]);
    write_sample(N - 1, sr[N-1], si[N-1]);
  endtask

  // Called at #1 after the edge that captured iaddr = N-1
  task automatic run_frame(input string nm, input bit noise);
    int cyc = 0;
    compute_model();
    if (noise) drive_noise();
    else       bus.ien = 1'b0;
    while (!bus.oen && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (noise) drive_noise();
    end
    check({nm, "_latency"}, cyc, LAT);
    for (int n = 0; n < N; n++) begin
      gr[n] = int'(bus.oReal);
      gi[n] = int'(bus.oImag);
      check($sformatf("%s_oen[%0d]", nm, n), bus.oen, 1);
      check($sformatf("%s_oaddr[%0d]", nm, n), bus.oaddr, n);
      check($sformatf("%s_re[%0d]", nm, n), bus.oReal, er[n]);
      check($sformatf("%s_im[%0d]", nm, n), bus.oImag, ei[n]);
      @(posedge clk);
      #1;
      if (noise && n < N - 1) drive_noise();
    end
    check({nm, "_oen_fall"}, bus.oen, 0);
    bus.ien = 1'b0;
  endtask

  task automatic stage_random(input int maxmag);
    for (int i = 0; i < N; i++) begin
      sr[i] = int'($urandom_range(0, 2 * maxmag)) - maxmag;
      si[i] = int'($urandom_range(0, 2 * maxmag)) - maxmag;
    end
  endtask

  task automatic stage_zero();
    for (int i = 0; i < N; i++) begin
      sr[i] = 0;
      si[i] = 0;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    for (int k = 0; k < HALF; k++) begin
      twr[k] = q14($cos(6.283185307179586 * k / N));
      twi[k] = q14($sin(6.283185307179586 * k / N));
    end
    rst_n     = 1'b0;
    bus.ien   = 1'b0;
    bus.iaddr = '0;
    bus.iReal = '0;
    bus.iImag = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_oen", bus.oen, 0);
    check("rst_oaddr", bus.oaddr, 0);
    check("rst_re", bus.oReal, 0);
    check("rst_im", bus.oImag, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    stage_zero();
    sr[0] = 1000;
    load_frame(0, 0);
    run_frame("impulse", 1'b0);
    check("impulse_re5", gr[5], 62);
    check("impulse_im9", gi[9], 0);

    stage_zero();
    sr[1] = 16000;
    load_frame(0, 0);
    run_frame("dir", 1'b0);
    check("dir_n4_re", (gr[4] >= -2 && gr[4] <= 2), 1);
    check("dir_n4_im", (gi[4] >= 998 && gi[4] <= 1002), 1);
    check("dir_n12_im", (gi[12] >= -1002 && gi[12] <= -998), 1);
    check("dir_n0_re", (gr[0] >= 998 && gr[0] <= 1002), 1);

    for (int i = 0; i < N; i++) begin
      sr[i] = 1600;
      si[i] = 0;
    end
    load_frame(0, 0);
    run_frame("const", 1'b0);
    check("const_re0", gr[0], 1600);
    check("const_im0", gi[0], 0);
    check("const_re7_small", (gr[7] >= -1 && gr[7] <= 1), 1);

    stage_random(3000);
    sr[6] = 32767;
    si[6] = 0;
    load_frame(1, 0);
    run_frame("desc_fs", 1'b0);

    for (int f = 0; f < 3; f++) begin
      stage_random((f == 0) ? 32767 : 8000);
      load_frame(2, 4);
      run_frame($sformatf("rand%0d", f), 1'b0);
    end

    stage_random(10000);
    load_frame(2, 0);
    bus.ien = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midcalc_rst_oen", bus.oen, 0);
    check("midcalc_rst_oaddr", bus.oaddr, 0);
    check("midcalc_rst_re", bus.oReal, 0);
    check("midcalc_rst_im", bus.oImag, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (LAT + N + 10) begin
      @(posedge clk);
      #1;
      if (bus.oen) seen = 1;
    end
    check("midcalc_no_oen", seen, 0);
    stage_random(20000);
    load_frame(2, 0);
    run_frame("after_rst", 1'b0);

    stage_random(20000);
    load_frame(2, 0);
    run_frame("b2b_a", 1'b1);
    stage_random(20000);
    load_frame(2, 0);
    run_frame("b2b_b", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
